thermo_ramp_gen: RTL and testbench

- Inverse of the 15-input ones counter: takes a 4-bit count and produces a 15-bit thermometer code whose popcount equals that count.
- Does not jump. It ramps the thermometer one bit per step toward the requested level, raising bits from bit 0 upward and dropping them from the top down.
- Drives stimulus/actuator lines that feed ones-counter paths. Round trip: feeding `thermo` into `my_counter_15_input` must always reproduce `level`.

---
 rtl/thermo_ramp_gen.sv | 111 +++++++++++
 tb/tb_thermo_ramp_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_ramp_gen.sv
// thermo_ramp_gen: turns a 4-bit level request into a 15-bit thermometer
// code. It walks there one bit per step: bits rise from bit 0 upward and
// fall from the top down, so a ones counter on thermo always reads level.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | target_ready high; waits for a target handshake
// RAMP  | busy high; one level step every STEP_CYCLES clocks toward tgt_q
// DONE  | done high for one cycle, then back to IDLE
module thermo_ramp_gen #(
   parameter int STEP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  target,
   input  logic        target_valid,
   output logic        target_ready,
   output logic [14:0] thermo,
   output logic [3:0]  level,
   output logic        busy,
   output logic        done,
   output logic        dir_up
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] STEP_TC = 8'(STEP_CYCLES - 1);

   state_t      state;
   logic [3:0]  tgt_q;
   logic [7:0]  timer;
   logic [3:0]  lvl_step;

   // thermo[i] is set exactly when the level is above i
   function automatic logic [14:0] decode(input logic [3:0] lvl);
      logic [14:0] t;
      for (int i = 0; i < 15; i++) begin
         t[i] = (int'(lvl) > i);
      end
      return t;
   endfunction

   // Level one step along the current direction; only used while ramping
   // toward a latched target, so it never leaves 0..15.
   always_comb begin
      lvl_step = dir_up ? (level + 4'd1) : (level - 4'd1);
   end

   // Sequencer: handshake, step timer, level/thermo update and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tgt_q        <= 4'd0;
         timer        <= 8'd0;
         level        <= 4'd0;
         thermo       <= 15'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         dir_up       <= 1'b1;
         target_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (target_valid) begin
                  tgt_q        <= target;
                  target_ready <= 1'b0;
                  if (target == level) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= RAMP;
                     busy   <= 1'b1;
                     timer  <= 8'd0;
                     dir_up <= (target > level);
                  end
               end
            end
            RAMP: begin
               if (timer == STEP_TC) begin
                  timer  <= 8'd0;
                  level  <= lvl_step;
                  thermo <= decode(lvl_step);
                  if (lvl_step == tgt_q) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            DONE: begin
               state        <= IDLE;
               done         <= 1'b0;
               target_ready <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               done         <= 1'b0;
               target_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_thermo_ramp_gen.sv
// Bench for thermo_ramp_gen: three instances with step lengths 1, 3 and 4.
// The driver queues each accepted command with its predicted accept edge; the
// monitor derives the expected level per cycle from elapsed time and step
// length, and retires the command when its done pulse is due.
module tb_thermo_ramp_gen;

   localparam int NI = 3;
   localparam int SC [NI] = '{1, 3, 4};

   typedef struct {
      int tgt;
      int lvl0;
      int e0;
   } cmd_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  tg  [NI];
   logic        tv  [NI];
   logic        rdy [NI];
   logic [14:0] th  [NI];
   logic [3:0]  lv  [NI];
   logic        bz  [NI];
   logic        dn  [NI];
   logic        du  [NI];

   cmd_t sbq [NI][$];
   int   idle_lvl [NI];
   int   idle_dir [NI];
   int   mdl_lvl  [NI];
   int   cyc;
   int   n_tot;
   int   n_pass;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      thermo_ramp_gen #(.STEP_CYCLES(SC[g])) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .target       (tg[g]),
         .target_valid (tv[g]),
         .target_ready (rdy[g]),
         .thermo       (th[g]),
         .level        (lv[g]),
         .busy         (bz[g]),
         .done         (dn[g]),
         .dir_up       (du[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s inst%0d (step %0d): got %0d, expected %0d, cycle %0d",
                    nm, k, SC[k], act, exp, cyc);
   endtask

   // Monitor: per-cycle expectation from elapsed time, retire on done
   always @(posedge clk) begin
      cyc = cyc + 1;
      #3;
      if (rst_n) begin
         for (int k = 0; k < NI; k++) begin
            int   e_lv, e_dn, e_bz, e_rd, e_du, d, n, st, up;
            cmd_t c;
            if (sbq[k].size() > 0) begin
               c  = sbq[k][0];
               d  = cyc - c.e0;
               up = (c.tgt > c.lvl0) ? 1 : 0;
               n  = up ? (c.tgt - c.lvl0) : (c.lvl0 - c.tgt);
               st = d / SC[k];
               if (st > n) st = n;
               e_lv = up ? (c.lvl0 + st) : (c.lvl0 - st);
               e_dn = (d == n * SC[k]) ? 1 : 0;
               e_bz = (d < n * SC[k]) ? 1 : 0;
               e_rd = 0;
               e_du = (n > 0) ? up : idle_dir[k];
            end else begin
               e_lv = idle_lvl[k];
               e_dn = 0;
               e_bz = 0;
               e_rd = 1;
               e_du = idle_dir[k];
            end
            chk("level", k, int'(lv[k]), e_lv);
            chk("thermo", k, int'(th[k]), (1 << e_lv) - 1);
            chk("popcount", k, $countones(th[k]), int'(lv[k]));
            chk("done", k, int'(dn[k]), e_dn);
            chk("busy", k, int'(bz[k]), e_bz);
            chk("target_ready", k, int'(rdy[k]), e_rd);
            chk("dir_up", k, int'(du[k]), e_du);
            if (e_dn != 0) begin
               if (dn[k]) chk("final_level", k, int'(lv[k]), c.tgt);
               void'(sbq[k].pop_front());
               idle_lvl[k] = c.tgt;
               idle_dir[k] = e_du;
            end
         end
      end
   end

   // Offer a target (held until accepted); call at a falling edge
   task automatic issue(input int k, input int t);
      int n;
      cmd_t c;
      tv[k] = 1'b1;
      tg[k] = 4'(t);
      n = 0;
      while (!rdy[k] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", k, (n < 2000) ? 1 : 0, 1);
      if (n < 2000) begin
         c.tgt  = t;
         c.lvl0 = mdl_lvl[k];
         c.e0   = cyc + 1;
         sbq[k].push_back(c);
         mdl_lvl[k] = t;
      end
      @(negedge clk);
      tv[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while ((sbq[k].size() != 0 || !rdy[k]) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", k, (n < 2000) ? 1 : 0, 1);
   endtask

   initial begin
      int n;
      cyc    = 0;
      n_tot  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      for (int k = 0; k < NI; k++) begin
         tv[k] = 1'b0;
         tg[k] = 4'd0;
         idle_lvl[k] = 0;
         idle_dir[k] = 1;
         mdl_lvl[k]  = 0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // full ramp up, one clock per step
      issue(0, 15);
      wait_idle(0);
      // ramp up then down, four clocks per step
      issue(2, 15);
      wait_idle(2);
      issue(2, 3);
      wait_idle(2);
      // equal target
      issue(0, 5);
      wait_idle(0);
      issue(0, 5);
      wait_idle(0);
      // back-pressure: 9 held while ramping to 2
      issue(1, 2);
      issue(1, 9);
      wait_idle(1);

      // random sweep, sometimes back-to-back with valid held
      for (int r = 0; r < 24; r++) begin
         int k;
         k = r % 2;
         issue(k, int'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1) wait_idle(k);
      end
      wait_idle(0);
      wait_idle(1);
      issue(0, 15);
      wait_idle(0);
      issue(0, 0);
      wait_idle(0);

      // reset mid-ramp at level 7, off any clock edge
      issue(0, 15);
      n = 0;
      while (lv[0] != 4'd7 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_7_timeout", 0, (n < 100) ? 1 : 0, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_thermo", 0, int'(th[0]), 0);
      chk("rst_level", 0, int'(lv[0]), 0);
      chk("rst_busy", 0, int'(bz[0]), 0);
      chk("rst_ready", 0, int'(rdy[0]), 1);
      chk("rst_dir_up", 0, int'(du[0]), 1);
      chk("rst_thermo", 2, int'(th[2]), 0);
      for (int k = 0; k < NI; k++) begin
         sbq[k].delete();
         idle_lvl[k] = 0;
         idle_dir[k] = 1;
         mdl_lvl[k]  = 0;
      end
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold_thermo", 0, int'(th[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2, 4);
      wait_idle(2);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
